// File: rtl/exe_div_unit_pkg.sv
// Shared definitions for the EX-stage radix-2 restoring divider:
// FSM state encodings, reset polarity and the divide-by-zero quotient.
package exe_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Reset is active-low: the enabled level is 0.
    localparam logic RST_ENABLED  = 1'b0;
    localparam logic RST_DISABLED = 1'b1;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/exe_div_unit_if.sv
// Request/result bundle between the ID/EX register, the divider and the hazard unit.
interface exe_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             div_sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             stall_req;

    modport master (
        output start, div_sign, dividend, divisor, flush,
        input  quotient, remainder, busy, done, stall_req
    );

    modport slave (
        input  start, div_sign, dividend, divisor, flush,
        output quotient, remainder, busy, done, stall_req
    );
endinterface

// File: rtl/exe_div_unit_div_lzc.sv
// Combinational leading-zero counter used by the divider's early-termination
// path (only instantiated when DIV_EARLY_TERM_EN is defined).
module div_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);
    logic found;

    always_comb begin
        count = CNT_W'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/exe_div_unit.sv
// Multi-cycle radix-2 restoring divider (lo = quotient, hi = remainder) with a
// stall request to the hazard unit. Optional macro: DIV_EARLY_TERM_EN.
module exe_div_unit
    import exe_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    exe_div_unit_if.slave bus
);
    div_state_t       state_reg, state_next;
    logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             q_neg_reg, r_neg_reg;
    logic             busy_reg, done_reg;

    logic             accept, div_zero, skip_calc;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, load_quo;
    logic [CNT_W-1:0] load_cnt;
    logic [WIDTH:0]   shift_rem, trial;

    assign accept   = (state_reg == DIV_IDLE) && bus.start && !bus.flush;
    assign div_zero = (bus.divisor == '0);
    assign dvd_mag  = (bus.div_sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign dvs_mag  = (bus.div_sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

`ifdef DIV_EARLY_TERM_EN
    logic [CNT_W-1:0] lz;

    div_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc (
        .value (dvd_mag),
        .count (lz)
    );

    // Leading zeros of the dividend never produce quotient bits, so skip them.
    assign load_quo  = dvd_mag << lz;
    assign load_cnt  = CNT_W'(WIDTH) - lz;
    assign skip_calc = (lz == CNT_W'(WIDTH));
`else
    assign load_quo  = dvd_mag;
    assign load_cnt  = CNT_W'(WIDTH);
    assign skip_calc = 1'b0;
`endif

    assign shift_rem = {rem_reg, quo_reg[WIDTH-1]};
    assign trial     = shift_rem - {1'b0, dvs_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLED) begin
            state_reg <= DIV_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == DIV_CALC) || (state_next == DIV_FIX);
            done_reg  <= (state_next == DIV_DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            DIV_IDLE: begin
                if (accept) begin
                    if (div_zero)       state_next = DIV_DONE;
                    else if (skip_calc) state_next = DIV_FIX;
                    else                state_next = DIV_CALC;
                end
            end
            DIV_CALC: if (cnt_reg == CNT_W'(1)) state_next = DIV_FIX;
            DIV_FIX:  state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
        endcase
        if (bus.flush) state_next = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLED) begin
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            cnt_reg       <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            unique case (state_reg)
                DIV_IDLE: begin
                    if (accept) begin
                        rem_reg   <= '0;
                        quo_reg   <= load_quo;
                        dvs_reg   <= dvs_mag;
                        cnt_reg   <= load_cnt;
                        q_neg_reg <= bus.div_sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_reg <= bus.div_sign && bus.dividend[WIDTH-1];
                        if (div_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                        end
                    end
                end
                DIV_CALC: begin
                    if (!bus.flush) begin
                        rem_reg <= trial[WIDTH] ? shift_rem[WIDTH-1:0] : trial[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                DIV_FIX: begin
                    if (!bus.flush) begin
                        quotient_reg  <= q_neg_reg ? -quo_reg : quo_reg;
                        remainder_reg <= r_neg_reg ? -rem_reg : rem_reg;
                    end
                end
                DIV_DONE: ;
            endcase
        end
    end

    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    // Low in DONE so ID/EX advances on the edge that retires the result.
    assign bus.stall_req = accept || (state_reg == DIV_CALC) || (state_reg == DIV_FIX);
endmodule

// File: tb/tb_exe_div_unit.sv
// Directed, table-driven bench for exe_div_unit plus flush/reset/back-to-back sequences.
module tb_exe_div_unit;
    import exe_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_div_unit_if #(.WIDTH(32)) bus ();

    exe_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_TERM_EN
        logic [31:0] mag;
        int lz;
`endif
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_TERM_EN
        mag = (sgn && a[31]) ? -a : a;
        lz = 32;
        for (int i = 31; i >= 0; i--) begin
            if (mag[i]) begin
                lz = 31 - i;
                break;
            end
        end
        return 32 - lz + 2;
`else
        return 34;
`endif
    endfunction

    // Issues one divide in the cycle after the previous one finished and waits for done.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic hold_start,
                           output logic [31:0] q, output logic [31:0] r,
                           output int lat, output int stalls);
        logic got;
        @(negedge clk);
        check("idle_done_low", {31'd0, bus.done}, 32'd0);
        check("idle_busy_low", {31'd0, bus.busy}, 32'd0);
        bus.start    = 1'b1;
        bus.div_sign = sgn;
        bus.dividend = a;
        bus.divisor  = b;
        #1;
        check("stall_on_start", {31'd0, bus.stall_req}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold_start) bus.start = 1'b0;
        lat = 0;
        stalls = 0;
        got = 1'b0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            if (bus.stall_req) stalls++;
            if (bus.done) begin
                got = 1'b1;
                lat = c;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
        bus.start = 1'b0;
        q = bus.quotient;
        r = bus.remainder;
        $display("div sign=%0d 0x%08h / 0x%08h -> q=0x%08h r=0x%08h lat=%0d stalls=%0d",
                 sgn, a, b, q, r, lat, stalls);
    endtask

    task automatic run_checked(input string tag, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic hold_start,
                               input logic [31:0] exp_q, input logic [31:0] exp_r);
        logic [31:0] q, r;
        int lat, stalls, el;
        run_div(sgn, a, b, hold_start, q, r, lat, stalls);
        el = exp_lat(sgn, a, b);
        check({tag, "_q"}, q, exp_q);
        check({tag, "_r"}, r, exp_r);
        check({tag, "_lat"}, lat, el);
        check({tag, "_stall"}, stalls, el - 1);
    endtask

    initial begin
        int done_cnt;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{1'b0, 32'h1234_5678,  32'd0,          DIV_ZERO_Q,     32'h1234_5678};
        vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'h8000_0001,  32'd0,          32'h8000_0000};
        vecs[7]  = '{1'b0, 32'd5,          32'd3,          32'd1,          32'd2};
        vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
        vecs[9]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1};
        vecs[10] = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd0,          DIV_ZERO_Q,     32'h8000_0000};

        bus.start    = 1'b0;
        bus.div_sign = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.flush    = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_quotient",  bus.quotient,  32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_done",      {31'd0, bus.done},      32'd0);
        check("rst_stall",     {31'd0, bus.stall_req}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_checked($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0,
                        vecs[i].exp_q, vecs[i].exp_r);
        end
        run_checked("signed_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        // Flush part-way through the iterations: no done, results retained.
        @(negedge clk);
        bus.start = 1'b1; bus.div_sign = 1'b0; bus.dividend = 32'hFFFF_0000; bus.divisor = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy",  {31'd0, bus.busy},      32'd0);
        check("flush_stall", {31'd0, bus.stall_req}, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("flush_no_done", done_cnt, 0);
        check("flush_keep_q", bus.quotient,  32'hFFFF_FFFD);
        check("flush_keep_r", bus.remainder, 32'hFFFF_FFFF);
        $display("flush mid-calc -> busy=%0d q=0x%08h r=0x%08h dones=%0d",
                 bus.busy, bus.quotient, bus.remainder, done_cnt);

        // Start together with flush in IDLE is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
        #1;
        check("startflush_stall", {31'd0, bus.stall_req}, 32'd0);
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("startflush_ignored", done_cnt, 0);
        $display("start+flush in idle -> activity cycles=%0d", done_cnt);

        // Start held high through the whole operation, then an immediate back-to-back divide.
        run_checked("held_start", 1'b0, 32'd7, 32'd2, 1'b1, 32'd3, 32'd1);
        run_checked("back2back",  1'b0, 32'd5, 32'd3, 1'b0, 32'd1, 32'd2);

        // Asynchronous reset in the middle of CALC clears outputs without a clock edge.
        @(negedge clk);
        bus.start = 1'b1; bus.div_sign = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_quotient",  bus.quotient,  32'd0);
        check("arst_remainder", bus.remainder, 32'd0);
        check("arst_busy",      {31'd0, bus.busy},      32'd0);
        check("arst_stall",     {31'd0, bus.stall_req}, 32'd0);
        $display("async reset mid-calc -> q=0x%08h r=0x%08h busy=%0d",
                 bus.quotient, bus.remainder, bus.busy);
        @(negedge clk);
        rst = 1'b1;
        run_checked("after_reset", 1'b0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
